payload_byte_feeder: RTL
========================

PAYLOAD_BYTE_FEEDER -- requirements
Module: payload_byte_feeder

Interface
REQ-001 SHALL have parameter BYTE_LANES, 8, number of byte lanes per input beat (data width = 8*BYTE_LANES).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port s_tdata  input  8*BYTE_LANES  payload beat; lane 0 (bits 7:0) is the earliest byte.
REQ-005 SHALL have port s_tkeep  input  BYTE_LANES  per-lane byte-valid mask.
REQ-006 SHALL have port s_tvalid  input  1  beat valid.
REQ-007 SHALL have port s_tlast  input  1  last beat of packet payload.
REQ-008 SHALL have port s_tready  output  1  beat accepted when s_tvalid and s_tready are both high at a clock edge.
REQ-009 SHALL have port sod  output  1  start-of-data pulse that clears all engine state registers.
REQ-010 SHALL have port en  output  1  byte-valid strobe; engine registers advance only when high.
REQ-011 SHALL have port byte_out  output  8  current payload byte.
REQ-012 SHALL have port char_vec  output  256  one-hot decode of byte_out; bit N high means byte value N; all-zero when en is low.
REQ-013 SHALL have port eop  output  1  one-cycle pulse after the last byte; downstream samples engine outputs on it.

Function
REQ-014 SHALL implement FSM states IDLE, SOD, STREAM, EOP.
REQ-015 In IDLE, SHALL drive s_tready=1; on accepting a beat, SHALL register data/keep/last and go to SOD.
REQ-016 In SOD, SHALL drive sod=1, en=0 for exactly one cycle, then go to STREAM.
REQ-017 In STREAM, SHALL present one kept byte per cycle with en=1, in ascending lane order, skipping lanes with tkeep=0.
REQ-018 byte_out, char_vec and en SHALL be registered outputs; the first byte appears the cycle after sod.
REQ-019 SHALL drive s_tready=1 in STREAM only in the cycle presenting the last kept byte of a non-last beat, so that a following beat is emitted with no bubble.
REQ-020 If s_tvalid is low when the next beat is needed, SHALL hold en=0, char_vec=0 until a beat is accepted, then resume.
REQ-021 After the last kept byte of the beat with tlast, SHALL go to EOP, drive eop=1 and en=0 for one cycle, then return to IDLE.
REQ-022 A beat with s_tkeep all zero SHALL emit no bytes; if it carries tlast, SHALL go directly to EOP, including as the first beat (SOD then EOP).
REQ-023 Back-to-back packets SHALL be separated by exactly eop, one IDLE cycle, and sod.
REQ-024 sod and eop SHALL never be high in the same cycle, and neither SHALL coincide with en=1.
REQ-025 s_tready SHALL be 0 in SOD and EOP.
REQ-026 Lane selection SHALL use a BYTE_LANES-bit remaining-byte mask, clearing the lowest set bit each emitted byte.

Reset
REQ-027 While rst is high, SHALL hold state=IDLE, sod=0, en=0, eop=0, byte_out=0x00, char_vec=0, s_tready=0, lane mask=0.
REQ-028 rst asserted mid-packet SHALL abort the packet with no eop; after rst falls, SHALL accept the next beat as a new packet.

Verification
REQ-029 Single beat, tdata=0x2F2E32254325_2F25 (lanes 0..7), tkeep=0xFF, tlast=1 -> sod at cycle 1; bytes 0x25,0x2F,0x25,0x43,0x25,0x32,0x2E,0x2F on cycles 2-9 with char_vec bits 37,47,37,67,37,50,46,47; eop at cycle 10.
REQ-030 Two beats, the second with tkeep=0x05, tlast=1, tvalid continuous -> 10 consecutive en cycles with no gap, then eop.
REQ-031 tvalid dropped for 3 cycles between beats -> exactly 3 cycles of en=0, char_vec=0 mid-packet; byte order preserved; no extra sod.
REQ-032 First beat tkeep=0x00, tlast=1 -> sod one cycle, eop the next cycle, zero en cycles.
REQ-033 rst pulsed during byte 4 of an 8-byte beat -> all outputs 0 immediately (asynchronous); no eop; next packet begins with sod.
REQ-034 Two back-to-back single-beat packets -> eop, IDLE, sod sequence; sod/eop/en mutually exclusive on every cycle.

Source files
------------

// File: rtl/payload_byte_feeder.sv
// Payload byte feeder: turns keep-masked multi-byte beats into a one-byte-per-cycle
// stream framed by sod/eop pulses, with a one-hot decode of each byte.
module payload_byte_feeder #(
  parameter int BYTE_LANES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*BYTE_LANES-1:0] s_tdata,
  input  logic [BYTE_LANES-1:0]   s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    sod,
  output logic                    en,
  output logic [7:0]              byte_out,
  output logic [255:0]            char_vec,
  output logic                    eop
);

  typedef enum logic [1:0] {
    IDLE,
    SOD,
    STREAM,
    EOP
  } state_t;

  localparam logic [BYTE_LANES-1:0] LANE_ONE = BYTE_LANES'(1);

  state_t                  state;
  state_t                  state_next;
  logic [8*BYTE_LANES-1:0] beat_data;
  logic [BYTE_LANES-1:0]   lane_mask;
  logic                    beat_last;

  logic                    capture;
  logic                    take;
  logic                    emit;
  logic [BYTE_LANES-1:0]   src_mask;
  logic [8*BYTE_LANES-1:0] src_data;
  logic [7:0]              pick;

  // State register; reset drops any packet in flight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshake, framing pulses, and which beat/mask the next byte comes from.
  // A beat taken in STREAM can supply its first byte in the same cycle, so the
  // source mask/data switch to the incoming beat to avoid a bubble.
  always_comb begin
    state_next = state;
    s_tready   = 1'b0;
    sod        = 1'b0;
    eop        = 1'b0;
    capture    = 1'b0;
    take       = 1'b0;
    emit       = 1'b0;
    src_mask   = lane_mask;
    src_data   = beat_data;
    case (state)
      IDLE: begin
        s_tready = !rst;
        if (s_tvalid && !rst) begin
          capture    = 1'b1;
          state_next = SOD;
        end
      end
      SOD: begin
        sod = 1'b1;
        if (lane_mask != '0) begin
          emit       = 1'b1;
          state_next = STREAM;
        end else if (beat_last) begin
          state_next = EOP;
        end else begin
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (lane_mask != '0) begin
          emit = 1'b1;
        end else if (beat_last) begin
          state_next = EOP;
        end else begin
          s_tready = 1'b1;
          if (s_tvalid) begin
            take     = 1'b1;
            src_mask = s_tkeep;
            src_data = s_tdata;
            if (s_tkeep != '0) begin
              emit = 1'b1;
            end else if (s_tlast) begin
              state_next = EOP;
            end
          end
        end
      end
      EOP: begin
        eop        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Select the byte in the lowest still-pending lane of the source beat.
  always_comb begin
    pick = 8'h00;
    for (int i = BYTE_LANES - 1; i >= 0; i--) begin
      if (src_mask[i]) begin
        pick = src_data[8*i +: 8];
      end
    end
  end

  // Beat storage and remaining-lane mask; each emitted byte clears the lowest set bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_data <= '0;
      lane_mask <= '0;
      beat_last <= 1'b0;
    end else if (capture) begin
      beat_data <= s_tdata;
      lane_mask <= s_tkeep;
      beat_last <= s_tlast;
    end else begin
      if (take) begin
        beat_data <= s_tdata;
        beat_last <= s_tlast;
      end
      if (take || emit) begin
        lane_mask <= src_mask & (src_mask - LANE_ONE);
      end
    end
  end

  // Registered byte outputs: strobe, byte value, and its one-hot decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en       <= 1'b0;
      byte_out <= 8'h00;
      char_vec <= '0;
    end else begin
      en <= emit;
      if (emit) begin
        byte_out <= pick;
        char_vec <= 256'd1 << pick;
      end else begin
        char_vec <= '0;
      end
    end
  end

endmodule
